// File: rtl/dt_skeleton.sv
// Skeleton extraction: scans the finished distance map and marks local maxima as medial-axis pixels.
// Optional macro SKEL_8NBR_EN extends the local-maximum test from 4 to 8 neighbours.
module dt_skeleton #(
  parameter int W_LOG2 = 7,
  parameter int H_LOG2 = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       res_rd,
  output logic [W_LOG2+H_LOG2-1:0]   res_addr,
  input  logic [7:0]                 res_di,
  output logic                       sk_wr,
  output logic [W_LOG2+H_LOG2-5:0]   sk_addr,
  output logic [15:0]                sk_do,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 max_dist,
  output logic [W_LOG2+H_LOG2:0]     skel_cnt
);

  localparam int AW = W_LOG2 + H_LOG2;
`ifdef SKEL_8NBR_EN
  localparam int NRD = 9;
`else
  localparam int NRD = 5;
`endif
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW-1:0] WIDTH_A = AW'(1) << W_LOG2;
  localparam logic [3:0]    LAST_RD = 4'(NRD - 1);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, RD3, RD4,
`ifdef SKEL_8NBR_EN
    RD5, RD6, RD7, RD8,
`endif
    WAIT, EVAL, WR, FIN
  } stateT;

  stateT               r_state;
  logic [AW-1:0]       r_p;
  logic [3:0]          r_rdIdx;
  logic [8*NRD-1:0]    r_nbr;
  logic [15:0]         r_acc;
  logic                r_resRd;
  logic [AW-1:0]       r_resAddr;
  logic                r_skWr;
  logic [AW-5:0]       r_skAddr;
  logic [15:0]         r_skDo;
  logic                r_busy;
  logic                r_done;
  logic [7:0]          r_maxDist;
  logic [AW:0]         r_skelCnt;

  logic                w_xFirst, w_xLast, w_yFirst, w_yLast;
  logic [15:0]         w_oob;
  logic [3:0]          w_capIdx;
  logic [7:0]          w_capVal;
  logic [7:0]          w_c;
  logic                w_bit;
  logic [AW-1:0]       w_pNext;

  // Read order index: 0=C 1=N 2=W 3=E 4=S 5=NW 6=NE 7=SW 8=SE, all wrapping mod 2^AW.
  function automatic logic [AW-1:0] nbrAddr(input logic [AW-1:0] pix, input logic [3:0] idx);
    case (idx)
      4'd1:    nbrAddr = pix - WIDTH_A;
      4'd2:    nbrAddr = pix - ONE_A;
      4'd3:    nbrAddr = pix + ONE_A;
      4'd4:    nbrAddr = pix + WIDTH_A;
      4'd5:    nbrAddr = pix - WIDTH_A - ONE_A;
      4'd6:    nbrAddr = pix - WIDTH_A + ONE_A;
      4'd7:    nbrAddr = pix + WIDTH_A - ONE_A;
      4'd8:    nbrAddr = pix + WIDTH_A + ONE_A;
      default: nbrAddr = pix;
    endcase
  endfunction

  assign w_xFirst = (r_p[W_LOG2-1:0] == '0);
  assign w_xLast  = &r_p[W_LOG2-1:0];
  assign w_yFirst = (r_p[AW-1:W_LOG2] == '0);
  assign w_yLast  = &r_p[AW-1:W_LOG2];
  assign w_pNext  = r_p + ONE_A;

  // Neighbours outside the image are still read, but their data is forced to zero.
  always_comb begin
    w_oob    = '0;
    w_oob[1] = w_yFirst;
    w_oob[2] = w_xFirst;
    w_oob[3] = w_xLast;
    w_oob[4] = w_yLast;
`ifdef SKEL_8NBR_EN
    w_oob[5] = w_yFirst | w_xFirst;
    w_oob[6] = w_yFirst | w_xLast;
    w_oob[7] = w_yLast  | w_xFirst;
    w_oob[8] = w_yLast  | w_xLast;
`endif
  end

  // Data returns two edges after its address, so each capture belongs to the previous read index.
  assign w_capIdx = (r_state == WAIT) ? LAST_RD : (r_rdIdx - 4'd1);
  assign w_capVal = w_oob[w_capIdx] ? 8'd0 : res_di;

  always_comb begin
    w_c   = r_nbr[8*NRD-1 -: 8];
    w_bit = (w_c != 8'd0);
    for (int i = 1; i < NRD; i++) begin
      if (w_c < r_nbr[8*(NRD-i)-1 -: 8]) w_bit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_p       <= '0;
      r_rdIdx   <= '0;
      r_nbr     <= '0;
      r_acc     <= '0;
      r_resRd   <= 1'b0;
      r_resAddr <= '0;
      r_skWr    <= 1'b0;
      r_skAddr  <= '0;
      r_skDo    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_maxDist <= '0;
      r_skelCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_maxDist <= '0;
            r_skelCnt <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            r_p       <= '0;
            r_acc     <= '0;
            r_rdIdx   <= '0;
            r_resRd   <= 1'b1;
            r_resAddr <= '0;
            r_state   <= RD0;
          end
        end
        RD0, RD1, RD2, RD3, RD4
`ifdef SKEL_8NBR_EN
        , RD5, RD6, RD7, RD8
`endif
        : begin
          if (r_rdIdx != 4'd0) r_nbr <= {r_nbr[8*NRD-9:0], w_capVal};
          if (r_rdIdx == LAST_RD) begin
            r_resRd <= 1'b0;
            r_state <= WAIT;
          end else begin
            r_rdIdx   <= r_rdIdx + 4'd1;
            r_resAddr <= nbrAddr(r_p, r_rdIdx + 4'd1);
            r_state   <= stateT'(r_state + 4'd1);
          end
        end
        WAIT: begin
          r_nbr   <= {r_nbr[8*NRD-9:0], w_capVal};
          r_state <= EVAL;
        end
        EVAL: begin
          r_acc <= {r_acc[14:0], w_bit};
          if (w_bit) r_skelCnt <= r_skelCnt + {{AW{1'b0}}, 1'b1};
          if (w_c > r_maxDist) r_maxDist <= w_c;
          if (&r_p[3:0]) begin
            r_skWr   <= 1'b1;
            r_skAddr <= r_p[AW-1:4];
            r_skDo   <= {r_acc[14:0], w_bit};
            r_state  <= WR;
          end else begin
            r_p       <= w_pNext;
            r_rdIdx   <= '0;
            r_resRd   <= 1'b1;
            r_resAddr <= w_pNext;
            r_state   <= RD0;
          end
        end
        WR: begin
          r_skWr <= 1'b0;
          r_acc  <= '0;
          if (&r_p) begin
            r_state <= FIN;
          end else begin
            r_p       <= w_pNext;
            r_rdIdx   <= '0;
            r_resRd   <= 1'b1;
            r_resAddr <= w_pNext;
            r_state   <= RD0;
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_rd   = r_resRd;
  assign res_addr = r_resAddr;
  assign sk_wr    = r_skWr;
  assign sk_addr  = r_skAddr;
  assign sk_do    = r_skDo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign max_dist = r_maxDist;
  assign skel_cnt = r_skelCnt;

endmodule

// File: tb/tb_dt_skeleton.sv
// Scoreboard bench for dt_skeleton on a 32x16 map; expected skeleton words are hand-computed.
module tb_dt_skeleton;

  localparam int WL    = 5;
  localparam int HL    = 4;
  localparam int AW    = WL + HL;
  localparam int SAW   = AW - 4;
  localparam int NPIX  = 1 << AW;
  localparam int WORDS = NPIX / 16;
  localparam int WIDTH = 1 << WL;
`ifdef SKEL_8NBR_EN
  localparam int CPP = 11;
`else
  localparam int CPP = 7;
`endif
  localparam int SCAN_CYC = WORDS * (16 * CPP + 1) + 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           res_rd;
  logic [AW-1:0]  res_addr;
  logic [7:0]     res_di = 8'd0;
  logic           sk_wr;
  logic [SAW-1:0] sk_addr;
  logic [15:0]    sk_do;
  logic           busy;
  logic           done;
  logic [7:0]     max_dist;
  logic [AW:0]    skel_cnt;

  typedef struct packed {
    logic [SAW-1:0] addr;
    logic [15:0]    data;
  } wrT;

  logic [7:0]  mem [NPIX];
  logic [15:0] expWords [WORDS];
  wrT          expQ [$];
  int          checks = 0;
  int          errors = 0;
  int          wrCount = 0;

  dt_skeleton #(.W_LOG2(WL), .H_LOG2(HL)) dut (
    .clk(clk), .reset(reset), .start(start),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .sk_wr(sk_wr), .sk_addr(sk_addr), .sk_do(sk_do),
    .busy(busy), .done(done), .max_dist(max_dist), .skel_cnt(skel_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
  end

  // Monitor: every skeleton write is matched against the next expected word.
  always @(negedge clk) begin : monitor
    wrT e;
    if (res_rd && sk_wr) begin
      errors++;
      $display("[TB] FAIL rdWrOverlap: res_rd=%0b sk_wr=%0b, required not both high", res_rd, sk_wr);
    end
    if (sk_wr) begin
      wrCount++;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedWrite: addr=%0d data=%04h, required no write", sk_addr, sk_do);
      end else begin
        e = expQ.pop_front();
        if (sk_addr !== e.addr || sk_do !== e.data) begin
          errors++;
          $display("[TB] FAIL skWord: got addr=%0d data=%04h, required addr=%0d data=%04h",
                   sk_addr, sk_do, e.addr, e.data);
        end
      end
    end
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic checkOutputsZero(input string tag);
    checkVal({tag, "Ctl"}, {28'd0, res_rd, sk_wr, busy, done}, 32'd0);
    checkVal({tag, "Addr"}, {18'd0, res_addr, sk_addr}, 32'd0);
    checkVal({tag, "Data"}, {8'd0, sk_do, max_dist}, 32'd0);
    checkVal({tag, "Cnt"}, {22'd0, skel_cnt}, 32'd0);
  endtask

  task automatic clearMap();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
  endtask

  task automatic setPix(input int x, input int y, input logic [7:0] v);
    mem[y * WIDTH + x] = v;
  endtask

  task automatic clearExp();
    for (int i = 0; i < WORDS; i++) expWords[i] = 16'h0000;
  endtask

  task automatic pushExpected();
    wrT item;
    for (int i = 0; i < WORDS; i++) begin
      item.addr = SAW'(i);
      item.data = expWords[i];
      expQ.push_back(item);
    end
  endtask

  // Launches one scan and waits for done; latency is counted in edges from start raise to done.
  task automatic applyStimulus(input bit toggleMid, input bit holdStart);
    int  cyc;
    bit  gotDone;
    wrCount = 0;
    pushExpected();
    @(negedge clk);
    start   = 1'b1;
    cyc     = 0;
    gotDone = 1'b0;
    while (cyc < 2 * SCAN_CYC && !gotDone) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1 && !holdStart) start = 1'b0;
      if (toggleMid && cyc == 1000) start = 1'b1;
      if (toggleMid && cyc == 1010) start = 1'b0;
      if (done) gotDone = 1'b1;
    end
    checkVal("scanLatency", cyc, SCAN_CYC);
  endtask

  task automatic checkOutput(input int expCnt, input int expMax);
    checkVal("skelCnt", {22'd0, skel_cnt}, expCnt);
    checkVal("maxDist", {24'd0, max_dist}, expMax);
    checkVal("busyAtDone", {31'd0, busy}, 32'd0);
    checkVal("doneLevel", {31'd0, done}, 32'd1);
    checkVal("writeCount", wrCount, WORDS);
    checkVal("pendingWrites", expQ.size(), 32'd0);
  endtask

  initial begin
    #(10 * 100000);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int expCnt;
    clearMap();
    #12;
    checkOutputsZero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    $display("[TB] all-zero map");
    clearExp();
    applyStimulus(1'b0, 1'b0);
    checkOutput(0, 0);

    $display("[TB] single pixel, start toggled mid-scan");
    setPix(10, 5, 8'd1);
    clearExp();
    expWords[10] = 16'h0020;
    applyStimulus(1'b1, 1'b0);
    checkOutput(1, 1);

    $display("[TB] 3x3 block");
    clearMap();
    for (int y = 5; y <= 7; y++)
      for (int x = 20; x <= 22; x++) setPix(x, y, 8'd1);
    setPix(21, 6, 8'd2);
    clearExp();
    expWords[13] = 16'h0400;
`ifdef SKEL_8NBR_EN
    expCnt = 1;
`else
    expWords[11] = 16'h0A00;
    expWords[15] = 16'h0A00;
    expCnt = 5;
`endif
    applyStimulus(1'b0, 1'b0);
    checkOutput(expCnt, 2);

    $display("[TB] row wrap");
    clearMap();
    setPix(0, 1, 8'd5);
    setPix(31, 0, 8'd9);
    clearExp();
    expWords[2] = 16'h8000;
    expWords[1] = 16'h0001;
    applyStimulus(1'b0, 1'b0);
    checkOutput(2, 9);

    $display("[TB] corner pixels");
    clearMap();
    setPix(0, 0, 8'd3);
    setPix(1, 0, 8'd3);
    clearExp();
    expWords[0] = 16'hC000;
    applyStimulus(1'b0, 1'b0);
    checkOutput(2, 3);

    $display("[TB] start held high, then reset mid-scan");
    clearMap();
    setPix(10, 5, 8'd1);
    clearExp();
    expWords[10] = 16'h0020;
    applyStimulus(1'b0, 1'b1);
    checkOutput(1, 1);
    wrCount = 0;
    pushExpected();
    @(posedge clk);
    #1;
    checkVal("restartBusyDone", {30'd0, busy, done}, 32'd2);
    start = 1'b0;
    cyc = 0;
    while (wrCount < WORDS / 2 && cyc < 2 * SCAN_CYC) begin
      @(negedge clk);
      cyc++;
    end
    checkVal("reachedMidScan", wrCount, WORDS / 2);
    #2;
    reset = 1'b0;
    expQ.delete();
    #1;
    checkOutputsZero("midReset");
    repeat (5) @(negedge clk);
    reset = 1'b1;
    wrCount = 0;
    repeat (300) @(negedge clk);
    checkVal("noWriteAfterReset", wrCount, 32'd0);
    checkVal("idleAfterReset", {29'd0, busy, done, res_rd}, 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dt_skeleton.md
Name: dt_skeleton

Overview:
- Downstream consumer of the distance-transform stage; launched by that stage's done.
- Scans the finished distance map in the res RAM and marks every local-maximum pixel as a skeleton (medial-axis) pixel.
- Packs the binary skeleton 16 pixels per word into a 1024-word skeleton RAM, and reports the maximum distance and the skeleton pixel count.

Parameters:
- W_LOG2, 7, log2 image width; width = 128.
- H_LOG2, 7, log2 image height; height = 128. Pixel address p = y*width + x, 14 bits by default.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; sampled only in IDLE; tied to the DT stage's done
- res_rd  out  1  distance-map read strobe
- res_addr  out  W_LOG2+H_LOG2  distance-map read address
- res_di  in  8  read data
- sk_wr  out  1  skeleton word write strobe
- sk_addr  out  W_LOG2+H_LOG2-4  skeleton word address
- sk_do  out  16  skeleton word; bit 15 = lowest x in the word
- busy  out  1  high from start acceptance until done rises
- done  out  1  level; high after the last word write, until the next accepted start
- max_dist  out  8  maximum pixel value seen in the scan
- skel_cnt  out  W_LOG2+H_LOG2+1  number of skeleton pixels

Behaviour:
- Reset (async, active-low): every output 0; FSM goes to IDLE; internal pixel counter p and bit accumulator cleared.
- Reset mid-scan: abort immediately; no pending write is completed.
- Memory timing:
  - res_addr/res_rd are registered at edge k; RAM samples them at edge k+1.
  - res_di is sampled by this block at edge k+2.
  - Reads are pipelined back to back.
- FSM states: IDLE, RD0..RD4, WAIT, EVAL, WR, FIN.
- IDLE:
  - start=1 → clear max_dist, skel_cnt, done and p; set busy=1; go to RD0.
  - start=0 → stay in IDLE.
- RD0..RD4: res_rd=1 for exactly 5 consecutive cycles. Read order: C=p, N=p-width, W=p-1, E=p+1, S=p+width, all modulo 2^(W_LOG2+H_LOG2).
- WAIT: res_rd=0; last datum (S) is captured.
- Out-of-image neighbours:
  - Cases: y=0 for N, x=0 for W, x=width-1 for E, y=height-1 for S.
  - The read is still issued; the captured value is replaced by 0.
  - No wrap between rows: the W neighbour of x=0 is never pixel p-1.
- EVAL:
  - Skeleton bit = (C != 0) && C >= N && C >= W && C >= E && C >= S. All compares unsigned 8-bit.
  - The bit is shifted into the accumulator at position 15-(x mod 16).
  - If the bit is set, skel_cnt increments. If C > max_dist, max_dist takes C.
  - If x mod 16 == 15, go to WR; otherwise p increments and go to RD0.
- WR:
  - sk_wr=1 for one cycle with sk_addr = p>>4 and sk_do = completed word; accumulator cleared.
  - If p is the last pixel, go to FIN; otherwise p increments and go to RD0.
- FIN: sk_wr=0, busy=0, done=1; go to IDLE.
- Timing: every pixel costs 7 cycles, plus 1 WR cycle per word = 113 cycles/word. Start to done = 1024*113 + 2 cycles. Exactly 1024 writes per scan, in ascending sk_addr order.
- sk_wr and res_rd are never high in the same cycle.
- start high while busy is ignored. start still high when FIN returns to IDLE → a new scan begins on the next cycle.
- Counters: skel_cnt cannot overflow (max 16384 fits in 15 bits). max_dist saturates naturally at 255.

Optional Feature:
- Macro SKEL_8NBR_EN.
- Defined:
  - Also reads NW, NE, SW, SE after S: RD0..RD8, 9 reads/pixel, 11 cycles/pixel, 177 cycles/word.
  - Skeleton rule requires C >= all 8 neighbours; diagonal out-of-image neighbours read as 0.
- Undefined: 4-neighbour rule and timing exactly as above.

Test Plan:
- All-zero map, start=1 → 1024 writes of 0x0000 at sk_addr 0..1023; skel_cnt=0; max_dist=0; done rises 115714 cycles after start acceptance.
- Single pixel value 1 at (x=10,y=5), rest 0 → word 40 = 0x0020, all other words 0x0000; skel_cnt=1; max_dist=1.
- 3x3 block at x=40..42, y=20..22 with values 1,1,1/1,2,1/1,1,1:
  - Default: word 162 = 0x00A0, word 170 = 0x0040, word 178 = 0x00A0; skel_cnt=5; max_dist=2.
  - SKEL_8NBR_EN: word 170 = 0x0040, words 162 and 178 = 0x0000; skel_cnt=1.
- Row-wrap check, (x=0,y=1)=5, (x=127,y=0)=9, rest 0 → word 8 = 0x8000, word 7 = 0x0001; skel_cnt=2.
- start toggled 0→1→0 mid-scan → no restart; still exactly 1024 writes. Then reset pulsed at word 500 → all outputs 0 immediately; no sk_wr until the next start; the rescan reproduces the same 1024 words.
- Corner pixel (0,0)=3, (1,0)=3, rest 0 → word 0 = 0xC000 (both pass the >= rule); skel_cnt=2; max_dist=3.
